// File: rtl/rst_seq.sv
// Reset sequencer: holds all reset channels, waits for a trusted clock-manager lock,
// then releases the channels one at a time in index order, STRETCH cycles apart.
module rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int STRETCH     = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              async_rst_i,
    input  logic              lock_i,
    input  logic              sw_rst_i,
    input  logic              lock_lost_clr_i,
    output logic [NUM_CH-1:0] rst_o,
    output logic              done_o,
    output logic              lock_lost_o,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(STRETCH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FLT_W = $clog2(LOCK_FILTER + 1);

    localparam logic [1:0] ST_ASSERT    = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(LOCK_FILTER);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FLT_W-1:0]       filt_q, filt_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CH-1:0]      rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   lost_q, lost_d;

    logic                   lock_s;
    logic                   lock_ok;
    logic                   release_now;
    logic                   abort_lock;
    logic [NUM_CH-1:0]      clear_vec;

    assign lock_s  = sync_q[SYNC_STAGES-1];
    assign lock_ok = (filt_q == FLT_MAX);

    always_comb begin
        filt_d = filt_q;
        if (!lock_s) begin
            filt_d = '0;
        end else if (filt_q != FLT_MAX) begin
            filt_d = filt_q + 1'b1;
        end
    end

    // Only a lock drop after release has started counts as an abort.
    assign abort_lock  = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_ok;
    assign release_now = (state_q == ST_RELEASE) && (cnt_q == CNT_LAST);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_clear
        assign clear_vec[gi] = release_now && (idx_q == IDX_W'(gi));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q & ~clear_vec;
        done_d  = done_q;
        lost_d  = lost_q;

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (release_now) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (abort_lock || sw_rst_i) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
        end

        // A simultaneous clear request loses against a new lock-loss event.
        if (abort_lock) begin
            lost_d = 1'b1;
        end else if (lock_lost_clr_i) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            sync_q  <= '0;
            filt_q  <= '0;
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], lock_i};
            filt_q  <= filt_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign rst_o       = rst_q;
    assign done_o      = done_q;
    assign lock_lost_o = lost_q;
    assign state_o     = state_q;

endmodule
